// File: rtl/bus_memory_responder_if.sv
// rtl/bus_memory_responder_if.sv - CPU bus control/address lines shared by master and responder
interface bus_memory_responder_if;
  logic [11:0] addressBus;
  logic        write;
  logic        sync;

  modport master (output addressBus, output write, output sync);
  modport slave  (input  addressBus, input  write, input  sync);
endinterface

// File: rtl/bus_memory_responder.sv
// rtl/bus_memory_responder.sv - RAM plus I/O page (ports, timer, fetch counter) on the CPU bus
module bus_memory_responder #(
  parameter logic [11:0] IO_BASE   = 12'hF00,
  parameter string       INIT_FILE = "",
  parameter int          PRESCALE  = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  bus_memory_responder_if.slave       bus,
  inout  wire  [7:0]                  dataBus,
  input  logic [7:0]                  portIn,
  output logic [7:0]                  portOut,
  output logic                        timerOverflow
);

  localparam int         RAM_DEPTH = int'(IO_BASE);
  localparam logic [7:0] PS_LAST   = 8'(PRESCALE - 1);

  // I/O register offsets within the page
  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_TLO  = 3'd2;
  localparam logic [2:0] OFF_THI  = 3'd3;
  localparam logic [2:0] OFF_TCTL = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
  localparam logic [2:0] OFF_FLO  = 3'd6;
  localparam logic [2:0] OFF_FHI  = 3'd7;

  logic [7:0]  r_ram [0:RAM_DEPTH-1];
  logic [7:0]  r_port_out;
  logic [7:0]  r_in_sync1;
  logic [7:0]  r_in_sync2;
  logic [15:0] r_timer;
  logic [7:0]  r_presc;
  logic        r_enable;
  logic        r_overflow;
  logic [7:0]  r_tmr_snap;
  logic [15:0] r_fetch;
  logic [7:0]  r_fetch_snap;

  logic        w_is_ram;
  logic [11:0] w_off;
  logic        w_io_hit;
  logic [2:0]  w_reg;
  logic        w_io_wr;
  logic        w_io_rd;
  logic        w_tick;
  logic        w_clr_tmr;
  logic        w_clr_ovf;
  logic        w_ovf_set;
  logic        w_clr_fetch;
  logic [7:0]  w_rd_data;

  assign w_is_ram  = (bus.addressBus < IO_BASE);
  assign w_off     = bus.addressBus - IO_BASE;
  assign w_io_hit  = !w_is_ram && (w_off < 12'd8);
  assign w_reg     = w_off[2:0];
  assign w_io_wr   = bus.write && w_io_hit;
  assign w_io_rd   = !bus.write && w_io_hit;

  // The prescaler wrap is the timer increment strobe; clear overrides it, so a
  // clear on the wrap edge can never produce an overflow.
  assign w_tick      = r_enable && (r_presc == PS_LAST);
  assign w_clr_tmr   = w_io_wr && (w_reg == OFF_TCTL) && dataBus[1];
  assign w_clr_ovf   = w_io_wr && (w_reg == OFF_STAT) && dataBus[0];
  assign w_ovf_set   = w_tick && (r_timer == 16'hFFFF) && !w_clr_tmr;
  assign w_clr_fetch = w_io_wr && ((w_reg == OFF_FLO) || (w_reg == OFF_FHI));

  // Combinational read mux for the address currently on the bus
  always_comb begin
    w_rd_data = 8'h00;
    if (w_is_ram) begin
      w_rd_data = r_ram[bus.addressBus];
    end else if (w_io_hit) begin
      case (w_reg)
        OFF_OUT:  w_rd_data = r_port_out;
        OFF_IN:   w_rd_data = r_in_sync2;
        OFF_TLO:  w_rd_data = r_timer[7:0];
        OFF_THI:  w_rd_data = r_tmr_snap;
        OFF_TCTL: w_rd_data = {7'd0, r_enable};
        OFF_STAT: w_rd_data = {7'd0, r_overflow};
        OFF_FLO:  w_rd_data = r_fetch[7:0];
        OFF_FHI:  w_rd_data = r_fetch_snap;
        default:  w_rd_data = 8'h00;
      endcase
    end
  end

  // Drive the bus only on read cycles; write cycles always see it released
  assign dataBus = bus.write ? 8'hzz : w_rd_data;

  // RAM write port; contents are deliberately untouched by reset
  always_ff @(posedge clock) begin
    if (reset_n && bus.write && w_is_ram) r_ram[bus.addressBus] <= dataBus;
  end

  // I/O page registers, timer, fetch counter and input synchroniser
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_port_out   <= 8'h00;
      r_in_sync1   <= 8'h00;
      r_in_sync2   <= 8'h00;
      r_timer      <= 16'h0000;
      r_presc      <= 8'h00;
      r_enable     <= 1'b0;
      r_overflow   <= 1'b0;
      r_tmr_snap   <= 8'h00;
      r_fetch      <= 16'h0000;
      r_fetch_snap <= 8'h00;
    end else begin
      r_in_sync1 <= portIn;
      r_in_sync2 <= r_in_sync1;

      if (w_io_wr && (w_reg == OFF_OUT))  r_port_out <= dataBus;
      if (w_io_wr && (w_reg == OFF_TCTL)) r_enable   <= dataBus[0];

      if (w_clr_tmr) begin
        r_timer <= 16'h0000;
        r_presc <= 8'h00;
      end else if (!r_enable) begin
        r_presc <= 8'h00;
      end else if (w_tick) begin
        r_presc <= 8'h00;
        r_timer <= r_timer + 16'd1;
      end else begin
        r_presc <= r_presc + 8'd1;
      end

      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (w_clr_ovf) r_overflow <= 1'b0;

      if (w_io_rd && (w_reg == OFF_TLO)) r_tmr_snap   <= r_timer[15:8];
      if (w_io_rd && (w_reg == OFF_FLO)) r_fetch_snap <= r_fetch[15:8];

      if (w_clr_fetch)   r_fetch <= 16'h0000;
      else if (bus.sync) r_fetch <= r_fetch + 16'd1;
    end
  end

  assign portOut       = r_port_out;
  assign timerOverflow = r_overflow;

endmodule
